// File: rtl/scaler_v.sv
// scaler_v: vertical linear-interpolation down-scaler.
// Previous-line buffer feeding a 3-stage blend pipeline.
module scaler_v #(
    parameter int DATA_WIDTH    = 8,
    parameter int LINE_SIZE_MAX = 4096,
    parameter int STEP_CORD_I   = 4096,
    parameter int COE_WIDTH     = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [15:0]           step_cord_o,
    input  logic [DATA_WIDTH-1:0] di_i,
    input  logic                  de_i,
    input  logic                  hs_i,
    input  logic                  vs_i,
    output logic [DATA_WIDTH-1:0] do_o,
    output logic                  de_o,
    output logic                  hs_o,
    output logic                  vs_o,
    output logic [15:0]           line_count_o
);
    localparam int AW = $clog2(LINE_SIZE_MAX);
    localparam int SH = $clog2(STEP_CORD_I) - COE_WIDTH;
    localparam int CW = COE_WIDTH + 1;
    localparam int PW = DATA_WIDTH + CW;
    localparam logic [15:0]        STEP_MIN = 16'(STEP_CORD_I);
    localparam logic signed [17:0] STEP_S   = 18'(STEP_CORD_I);
    localparam logic [CW-1:0]      COE_ONE  = CW'(1 << COE_WIDTH);
    localparam logic [PW:0]        RND      = (PW+1)'(1 << (COE_WIDTH-1));

    typedef enum logic [1:0] {WAIT_VS, FRAME_IDLE, ACTIVE} state_t;

    state_t                 state_q;
    logic                   hs_prev_q;
    logic                   in_line_q;
    logic                   emit_q;
    logic                   line0_q;
    logic [COE_WIDTH-1:0]   coe_prev_q;
    logic signed [17:0]     rem_q;
    logic [15:0]            k_q;
    logic [15:0]            s_q;
    logic [15:0]            x_q;
    logic [15:0]            cnt_q;

    logic                   run;
    logic                   line_start;
    logic                   line_end;
    logic                   line_on;
    logic                   pix_ok;
    logic                   in_rng;
    logic                   wr_en;
    logic                   emit_now;
    logic                   emit_line;
    logic                   line0;
    logic [17:0]            neg_rem;
    logic [COE_WIDTH-1:0]   coe_now;
    logic [COE_WIDTH-1:0]   coe_line;
    logic [CW-1:0]          coe_c;
    logic [15:0]            x_eff;
    logic                   de_s0;
    logic                   hs_s0;

    assign run        = (state_q == ACTIVE) && !vs_i;
    assign line_start = run && !hs_i && hs_prev_q;
    assign line_end   = (state_q == ACTIVE) && hs_i && !hs_prev_q;
    assign line_on    = run && !hs_i && (line_start || in_line_q);
    assign emit_now   = (rem_q <= 18'sd0);
    assign neg_rem    = 18'(-rem_q);
    assign coe_now    = COE_WIDTH'(neg_rem >> SH);
    assign emit_line  = line_start ? emit_now : emit_q;
    assign coe_line   = line_start ? coe_now : coe_prev_q;
    assign line0      = line_start ? (k_q == 16'd0) : line0_q;
    assign x_eff      = line_start ? 16'd0 : x_q;
    assign pix_ok     = line_on && de_i;
    assign in_rng     = x_eff < 16'(LINE_SIZE_MAX);
    assign wr_en      = pix_ok && in_rng && rst;
    assign coe_c      = COE_ONE - {1'b0, coe_line};
    assign de_s0      = pix_ok && in_rng && emit_line;
    assign hs_s0      = hs_i || (state_q == WAIT_VS)
                      || (line_on && !emit_line);

    // frame FSM, line position tracking and pixel counter
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= WAIT_VS;
            hs_prev_q  <= 1'b1;
            in_line_q  <= 1'b0;
            emit_q     <= 1'b0;
            line0_q    <= 1'b0;
            coe_prev_q <= '0;
            rem_q      <= '0;
            k_q        <= '0;
            s_q        <= STEP_MIN;
            x_q        <= '0;
            cnt_q      <= '0;
        end else begin
            hs_prev_q <= hs_i;
            in_line_q <= line_on;
            unique case (state_q)
                WAIT_VS: begin
                    if (vs_i) state_q <= FRAME_IDLE;
                end
                FRAME_IDLE: begin
                    if (!vs_i) begin
                        state_q <= ACTIVE;
                        s_q     <= (step_cord_o < STEP_MIN) ?
                                   STEP_MIN : step_cord_o;
                        rem_q   <= '0;
                        k_q     <= '0;
                        cnt_q   <= '0;
                    end
                end
                ACTIVE: begin
                    if (vs_i) state_q <= FRAME_IDLE;
                end
                default: state_q <= WAIT_VS;
            endcase
            if (line_start) begin
                emit_q     <= emit_now;
                coe_prev_q <= emit_now ? coe_now : '0;
                line0_q    <= (k_q == 16'd0);
                if (emit_now) begin
                    rem_q <= rem_q + $signed({2'b00, s_q});
                    cnt_q <= cnt_q + 16'd1;
                end
            end
            if (line_end) begin
                rem_q <= rem_q - STEP_S;
                k_q   <= k_q + 16'd1;
            end
            if (line_start) x_q <= '0;
            if (pix_ok && x_eff != '1) x_q <= x_eff + 16'd1;
        end
    end

    logic [DATA_WIDTH-1:0] mem [LINE_SIZE_MAX];
    logic [DATA_WIDTH-1:0] rd_q;
    logic [AW-1:0]         addr;

    assign addr = x_eff[AW-1:0];

    // line buffer, old contents returned on a same-address write
    always_ff @(posedge clk) begin
        if (wr_en) mem[addr] <= di_i;
        if (pix_ok) rd_q <= mem[addr];
    end

    logic [DATA_WIDTH-1:0] cur1_q;
    logic [COE_WIDTH-1:0]  coe_p1_q;
    logic [CW-1:0]         coe_c1_q;
    logic                  zero1_q;
    logic                  de1_q, hs1_q, vs1_q;
    logic [PW-1:0]         mp2_q, mc2_q;
    logic                  de2_q, hs2_q, vs2_q;
    logic [DATA_WIDTH-1:0] do_q;
    logic                  de_q, hs_q, vs_q;
    logic [DATA_WIDTH-1:0] prev1;
    logic [PW-1:0]         mp, mc;
    logic [PW:0]           sum3;

    assign prev1 = zero1_q ? '0 : rd_q;
    assign mp    = PW'(prev1) * PW'(coe_p1_q);
    assign mc    = PW'(cur1_q) * PW'(coe_c1_q);
    assign sum3  = {1'b0, mp2_q} + {1'b0, mc2_q} + RND;

    // blend pipeline: capture, multiply, round to output
    always_ff @(posedge clk) begin
        if (!rst) begin
            cur1_q   <= '0;
            coe_p1_q <= '0;
            coe_c1_q <= '0;
            zero1_q  <= 1'b1;
            de1_q    <= 1'b0;
            hs1_q    <= 1'b1;
            vs1_q    <= 1'b1;
            mp2_q    <= '0;
            mc2_q    <= '0;
            de2_q    <= 1'b0;
            hs2_q    <= 1'b1;
            vs2_q    <= 1'b1;
            do_q     <= '0;
            de_q     <= 1'b0;
            hs_q     <= 1'b1;
            vs_q     <= 1'b1;
        end else begin
            cur1_q   <= di_i;
            coe_p1_q <= coe_line;
            coe_c1_q <= coe_c;
            zero1_q  <= line0;
            de1_q    <= de_s0;
            hs1_q    <= hs_s0;
            vs1_q    <= vs_i;
            mp2_q    <= mp;
            mc2_q    <= mc;
            de2_q    <= de1_q;
            hs2_q    <= hs1_q;
            vs2_q    <= vs1_q;
            do_q     <= DATA_WIDTH'(sum3 >> COE_WIDTH);
            de_q     <= de2_q;
            hs_q     <= hs2_q;
            vs_q     <= vs2_q;
        end
    end

    assign do_o         = do_q;
    assign de_o         = de_q;
    assign hs_o         = hs_q;
    assign vs_o         = vs_q;
    assign line_count_o = cnt_q;

endmodule

// File: doc/scaler_v.md
# scaler_v

Vertical linear-interpolation down-scaler placed directly downstream of `scaler_h`. It consumes the horizontally scaled de/hs/vs pixel stream and stores the previous input line in an internal line buffer. For each output row, it blends the stored line with the line currently arriving, using a 4.12 fixed-point step. It produces at most one output line per input line, so output runs concurrently with input and needs no back-pressure.

## Interface
- `DATA_WIDTH`, 8, pixel width.
- `LINE_SIZE_MAX`, 4096, line buffer depth in pixels.
- `STEP_CORD_I`, 4096, input line pitch in step units. Must be a power of two and ≥ 2^COE_WIDTH.
- `COE_WIDTH`, 10, interpolation coefficient width.
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-low reset.
- `step_cord_o`  in  16  output line pitch, 4.12 unsigned. 4096 means 1.0. Sampled at frame start.
- `di_i`  in  DATA_WIDTH  pixel data.
- `de_i`  in  1  pixel valid.
- `hs_i`  in  1  high during horizontal blanking.
- `vs_i`  in  1  high during vertical blanking.
- `do_o`  out  DATA_WIDTH  interpolated pixel.
- `de_o`  out  1  output pixel valid.
- `hs_o`  out  1  output horizontal blanking.
- `vs_o`  out  1  output vertical blanking.
- `line_count_o`  out  16  output lines emitted in the current frame.

## Operation
- **Input protocol**
  - Line start is the first cycle with hs_i=0 after a cycle with hs_i=1. Line end is the hs_i 0→1 transition.
  - Frame start is the vs_i 1→0 transition. Frame end is vs_i 0→1.
  - de_i is ignored while hs_i=1 or vs_i=1.
- **FSM**
  - WAIT_VS: entered on reset. Moves to FRAME_IDLE when vs_i=1.
  - FRAME_IDLE: on vs_i=0, latches `s = max(step_cord_o, STEP_CORD_I)`, clears rem, k and line_count_o, then moves to ACTIVE.
  - ACTIVE: moves back to FRAME_IDLE on vs_i=1.
- **Position register `rem`**
  - Signed, 18 bits. Holds (next output row position) − (k·STEP_CORD_I), where k is the current input line index.
  - At line start, compute emit = (rem ≤ 0) combinationally and latch it for the line.
  - If emit: coe_prev = (−rem) >> (log2(STEP_CORD_I) − COE_WIDTH), coe_cur = 2^COE_WIDTH − coe_prev, then rem += s. Increment line_count_o once.
  - At line end: rem −= STEP_CORD_I, k += 1.
  - Because s ≥ STEP_CORD_I, −STEP_CORD_I < rem ≤ 0 whenever emit=1.
- **Line buffer**
  - LINE_SIZE_MAX × DATA_WIDTH RAM with read-before-write at the same address.
  - Pixel counter x clears at line start and increments on each valid de_i.
  - At each valid pixel, read prev[x] and write di_i to [x].
  - Pixels with x ≥ LINE_SIZE_MAX are not written and not output.
- **Datapath**
  - do = (prev·coe_prev + cur·coe_cur + 2^(COE_WIDTH−1)) >> COE_WIDTH. The blend is convex, so no saturation is needed.
  - On line 0 of a frame, prev is forced to 0. coe_prev is 0 because rem=0 on that line.
- **Line emission**
  - Lines with emit=0 produce de_o=0 and hold hs_o=1 for their whole duration. A dropped line is pure blanking downstream.
  - vs_o is always vs_i delayed.

## Timing
- Fixed latency of 3 cycles from input to output for do_o, de_o, hs_o and vs_o:
  - stage 1: RAM read and input register;
  - stage 2: multiplies;
  - stage 3: add, round and output register.
- Idle cycles in de_i gaps pass through unchanged. Cycle spacing is preserved.
- Reset values: do_o=0, de_o=0, hs_o=1, vs_o=1, line_count_o=0. All pipeline stages are cleared.
- **Reset mid-frame**
  - Outputs take their reset values on the cycle after rst is sampled low.
  - After reset is released, the block stays in WAIT_VS. No de_o is asserted until a complete new frame begins.
- step_cord_o changes inside a frame have no effect until the next frame start.
- step_cord_o < STEP_CORD_I is clamped to STEP_CORD_I, giving pass-through.
- A line start coinciding with the first de_i (same cycle) is legal, and that pixel is processed.

## Test plan
- **Pass-through:** step_cord_o=4096, 25×25 ramp frame, 2 frames → output equals input bit-exactly, 25 lines/frame, latency 3, line_count_o=25.
- **Decimate by 2:** step_cord_o=8192, line k constant value 10k → 13 lines with values 0,20,…,240; line_count_o=13; dropped lines have hs_o=1 and de_o=0.
- **Fractional 1.5:** step_cord_o=6144, line k constant 10k → outputs 0,15,30,45,…. Output line 1 is emitted during input line 2 with coe_prev=512: (10·512 + 20·512 + 512) >> 10 = 15.
- **Clamp:** step_cord_o=2048 → identical to the pass-through case.
- **Reset mid-frame:** rst=0 for 2 cycles during line 10 → de_o=0, hs_o=1, vs_o=1 next cycle; nothing output for the remainder of the frame; the next frame matches pass-through.
- **Gaps/overflow:** de_i gaps every other cycle, and one line of LINE_SIZE_MAX+4 pixels → gaps are preserved at the output; the last 4 pixels are not output and buffer contents are intact.
